// File: rtl/detector_frecuencias_if.sv
// ---------------------------------------------------------------------------
// detector_frecuencias_if
// Groups the measured switching signal and the detector's monitor outputs.
//   fsw            switching signal under measurement (driven by the source)
//   selector       last locked frequency code
//   bloqueado      high while locked onto a valid code
//   medida_valida  1-clk pulse per in-tolerance measurement
//   sin_senal      1-clk pulse when the period times out
//   periodo        last completed measured period in clk cycles
// Modports: master = side that drives fsw and watches results,
//           slave  = the detector itself.
// ---------------------------------------------------------------------------
interface detector_frecuencias_if #(
    parameter int CNT_W = 17
);
    logic             fsw;
    logic [2:0]       selector;
    logic             bloqueado;
    logic             medida_valida;
    logic             sin_senal;
    logic [CNT_W-1:0] periodo;

    modport master (
        output fsw,
        input  selector,
        input  bloqueado,
        input  medida_valida,
        input  sin_senal,
        input  periodo
    );

    modport slave (
        input  fsw,
        output selector,
        output bloqueado,
        output medida_valida,
        output sin_senal,
        output periodo
    );
endinterface

// File: rtl/detector_frecuencias.sv
// ---------------------------------------------------------------------------
// detector_frecuencias
// Measures the period of the switching signal fsw and decodes it back into
// the 3-bit frequency code k (period 2^(BASE_LOG2+k) clk cycles). Confirms
// that the frequency selected for the PWM stage is really on the output.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    detector_frecuencias_if.slave (fsw in; selector, bloqueado,
//          medida_valida, sin_senal, periodo out, all registered)
//
// Configuration macro: DETECTOR_FILTRO_EN
//   defined   -> LOCK_CNT consecutive matching measurements needed to lock
//   undefined -> every valid measurement locks immediately
// ---------------------------------------------------------------------------
module detector_frecuencias #(
    parameter int BASE_LOG2 = 8,
    parameter int TOL       = 8,
    parameter int LOCK_CNT  = 2,
    parameter int CNT_W     = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    detector_frecuencias_if.slave   bus
);

`ifdef DETECTOR_FILTRO_EN
    localparam bit FILTRO = 1'b1;
`else
    localparam bit FILTRO = 1'b0;
`endif

    // Without the filter a single matching measurement is enough to lock,
    // so the same lock path is used with an effective count of one.
    localparam logic [2:0]       LOCK_EFF    = FILTRO ? 3'(LOCK_CNT) : 3'd1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'((1 << (BASE_LOG2 + 7)) + TOL);

    typedef enum logic {
        ESPERA,
        MIDE
    } state_t;

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_periodo;
    logic [2:0]       r_selector;
    logic             r_bloqueado;
    logic             r_medida_valida;
    logic             r_sin_senal;
    logic [2:0]       r_cand;
    logic [2:0]       r_match;

    logic             w_edge;
    logic             w_timeout;
    logic             w_valida;
    logic [2:0]       w_code;
    logic [2:0]       w_match_next;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // fsw is asynchronous: two flops for metastability, a third to detect
    // the rising edge on clean, synchronized values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.fsw;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge    = r_s2 & ~r_s3;
    assign w_timeout = (r_state == MIDE) && (r_cnt > TIMEOUT_LIM);

    // Classify the running count as a period. TOL is below half the
    // smallest nominal period, so at most one code can match.
    always_comb begin
        w_valida = 1'b0;
        w_code   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (abs_diff(r_cnt, CNT_W'(1) << (BASE_LOG2 + k)) <= CNT_W'(TOL)) begin
                w_valida = 1'b1;
                w_code   = 3'(k);
            end
        end
    end

    // Consecutive-match counter: repeat of the candidate increments up to
    // the lock count, a new code restarts the run at one.
    always_comb begin
        w_match_next = 3'd1;
        if (w_code == r_cand) begin
            w_match_next = (r_match < LOCK_EFF) ? (r_match + 3'd1) : r_match;
        end
    end

    // Measurement FSM. A timeout takes priority over a simultaneous edge;
    // that edge then serves as the new reference instead of a measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ESPERA;
            r_cnt           <= '0;
            r_periodo       <= '0;
            r_selector      <= 3'd0;
            r_bloqueado     <= 1'b0;
            r_medida_valida <= 1'b0;
            r_sin_senal     <= 1'b0;
            r_cand          <= 3'd0;
            r_match         <= 3'd0;
        end else begin
            r_medida_valida <= 1'b0;
            r_sin_senal     <= 1'b0;
            case (r_state)
                ESPERA: begin
                    if (w_edge) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= MIDE;
                    end
                end
                MIDE: begin
                    if (w_timeout) begin
                        r_sin_senal <= 1'b1;
                        r_bloqueado <= 1'b0;
                        r_match     <= 3'd0;
                        if (w_edge) begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= MIDE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ESPERA;
                        end
                    end else if (w_edge) begin
                        r_periodo <= r_cnt;
                        r_cnt     <= CNT_W'(1);
                        if (w_valida) begin
                            r_medida_valida <= 1'b1;
                            r_cand          <= w_code;
                            r_match         <= w_match_next;
                            if (w_match_next == LOCK_EFF) begin
                                r_selector  <= w_code;
                                r_bloqueado <= 1'b1;
                            end else if (w_code != r_selector) begin
                                r_bloqueado <= 1'b0;
                            end
                        end else begin
                            r_bloqueado <= 1'b0;
                            r_match     <= 3'd0;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ESPERA;
                end
            endcase
        end
    end

    assign bus.selector      = r_selector;
    assign bus.bloqueado     = r_bloqueado;
    assign bus.medida_valida = r_medida_valida;
    assign bus.sin_senal     = r_sin_senal;
    assign bus.periodo       = r_periodo;

endmodule
